banked_ram: RTL
===============

Name: banked_ram

Overview:
Parametrised, banked work-RAM slave for the CPU memory bus, the next generation of the flat internal RAM. It maps a fixed bank-0 window and a switchable bank window, selected through a memory-mapped bank register (GBC SVBK style). A req/ready handshake with configurable wait states replaces the fixed single-cycle access. Out-of-range accesses complete with open-bus data.

Parameters:
DATA_W, 8, data bus width
ADDR_W, 16, address bus width
BASE, 16'hC000, first address of the fixed bank-0 window
WIN_BYTES, 4096, size of the fixed bank-0 window; the switchable window starts at BASE+WIN_BYTES
BANK_BYTES, 4096, size of each switchable bank and of the switchable window
NUM_BANKS, 8, total banks including bank 0; power of 2 and >= 2; BANK_W = $clog2(NUM_BANKS)
BANK_REG_ADDR, 16'hFF70, address of the bank-select register
WAIT_STATES, 0, extra cycles between accept and ready; allowed range 0..15
OPEN_BUS, 8'hFF, rdata returned for unmapped reads

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req  in  1  access request
wr  in  1  1 = write, 0 = read; sampled at accept
adr  in  ADDR_W  byte address; sampled at accept
wdata  in  DATA_W  write data; sampled at accept
ready  out  1  one-cycle pulse marking access completion
rdata  out  DATA_W  read data; valid while ready = 1, held until the next completion
hit  out  1  registered with ready: 1 if the completed access decoded to RAM or the bank register
bank  out  BANK_W  current raw bank-select register value

Behaviour:
- Reset values: state IDLE, ready 0, hit 0, rdata OPEN_BUS, bank 1, wait counter 0. RAM contents are not reset.
- A reset asserted mid-access aborts the access. A pending write is not committed and no ready is produced.
- FSM states: IDLE, WAIT, DONE.
- IDLE: when req = 1, capture wr, adr and wdata. Go to DONE if WAIT_STATES = 0, otherwise go to WAIT with counter = WAIT_STATES-1.
- WAIT: decrement the counter each cycle; go to DONE when it reaches 0.
- DONE: perform the access, assert ready, update rdata and hit, then return to IDLE. req is ignored in WAIT and DONE.
- Latency: ready is asserted WAIT_STATES+1 cycles after the accept edge. Minimum spacing between accepts is WAIT_STATES+2 cycles.
- Decode uses the captured address:
  - Fixed window: BASE <= adr < BASE+WIN_BYTES maps to bank 0, offset adr-BASE.
  - Switchable window: BASE+WIN_BYTES <= adr < BASE+WIN_BYTES+BANK_BYTES maps to bank eff, offset adr-BASE-WIN_BYTES.
  - eff = (bank == 0) ? 1 : bank. Bank 0 is never selectable in the switchable window.
  - adr == BANK_REG_ADDR: a write sets bank <= wdata[BANK_W-1:0]; a read returns {ones in upper DATA_W-BANK_W bits, bank}.
  - Any other address: hit = 0, rdata = OPEN_BUS, and writes are dropped. ready still pulses.
- Storage is NUM_BANKS*BANK_BYTES words. Bank 0 storage is shared by the fixed window only. This requires WIN_BYTES == BANK_BYTES, checked by an elaboration assertion.
- A write commits on the DONE cycle. A read in the same transaction returns the pre-write contents (not applicable, since one op per transaction).
- A bank-register write takes effect for any access completing on a later cycle.

Test Plan:
- Reset, then WAIT_STATES=0: write 8'hA5 to C010, then read C010 -> ready one cycle after each accept; rdata=A5, hit=1.
- Bank switching: write 02 to FF70, write 8'h11 to D000; write 03 to FF70, write 8'h22 to D000; write 02 to FF70 and read D000 -> 11; read FF70 -> F8|2 = 8'hFA, bank=2.
- Bank 0 alias: write 00 to FF70, then read D000 -> returns bank-1 data. Write 8'h33 to C000, then read D000 -> not 33.
- Unmapped access: read 8000 -> ready pulses, hit=0, rdata=FF. A write to E000 followed by reads show no RAM change.
- WAIT_STATES=3: req held high continuously -> ready at accept+4 cycles, accepts every 5 cycles. req toggling during WAIT has no effect.
- Reset pulse while in WAIT with a pending write 8'h77 to C020 -> no ready; bank=1 after reset; a subsequent read of C020 does not return 77.

Source files
------------

// File: rtl/banked_ram.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// banked_ram
//   Banked work-RAM slave for the CPU memory bus. A fixed window at BASE always
//   maps bank 0; the window directly above it maps the bank chosen by a
//   memory-mapped bank-select register (bank 0 there aliases to bank 1).
//   Accesses use a req/ready handshake with WAIT_STATES extra cycles between
//   accept and completion. Unmapped accesses still complete, with open-bus data.
//
// Ports
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   req    in   access request, accepted only while idle
//   wr     in   1 = write, 0 = read (sampled at accept)
//   adr    in   byte address (sampled at accept)
//   wdata  in   write data (sampled at accept)
//   ready  out  one-cycle completion pulse
//   rdata  out  read data, valid with ready and held until the next completion
//   hit    out  1 if the completed access decoded to RAM or the bank register
//   bank   out  raw bank-select register value
// -----------------------------------------------------------------------------
module banked_ram #(
  parameter int                DATA_W        = 8,
  parameter int                ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] BASE          = 16'hC000,
  parameter int                WIN_BYTES     = 4096,
  parameter int                BANK_BYTES    = 4096,
  parameter int                NUM_BANKS     = 8,
  parameter logic [ADDR_W-1:0] BANK_REG_ADDR = 16'hFF70,
  parameter int                WAIT_STATES   = 0,
  parameter logic [DATA_W-1:0] OPEN_BUS      = 8'hFF,
  localparam int               BANK_W        = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic [BANK_W-1:0] bank
);

  localparam int OFF_W  = $clog2(BANK_BYTES);
  localparam int MEM_AW = BANK_W + OFF_W;
  localparam int DEPTH  = NUM_BANKS * BANK_BYTES;
  localparam int CNT_W  = 4;
  localparam int AW1    = ADDR_W + 1;

  // Window bounds carry one extra bit so BASE+size cannot wrap at the top of
  // the address space.
  localparam logic [ADDR_W:0] FIX_LO = {1'b0, BASE};
  localparam logic [ADDR_W:0] FIX_HI = FIX_LO + AW1'(WIN_BYTES);
  localparam logic [ADDR_W:0] SW_HI  = FIX_HI + AW1'(BANK_BYTES);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  // Bank 0 storage backs the fixed window, so both windows must be bank-sized.
  if (WIN_BYTES != BANK_BYTES) begin : g_chk_win
    $error("banked_ram: WIN_BYTES (%0d) must equal BANK_BYTES (%0d)", WIN_BYTES, BANK_BYTES);
  end
  if ((NUM_BANKS < 2) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_chk_banks
    $error("banked_ram: NUM_BANKS (%0d) must be a power of 2 and >= 2", NUM_BANKS);
  end
  if ((BANK_BYTES < 2) || ((BANK_BYTES & (BANK_BYTES - 1)) != 0)) begin : g_chk_bank_bytes
    $error("banked_ram: BANK_BYTES (%0d) must be a power of 2", BANK_BYTES);
  end
  if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_chk_wait
    $error("banked_ram: WAIT_STATES (%0d) must be in 0..15", WAIT_STATES);
  end
  if (DATA_W <= BANK_W) begin : g_chk_width
    $error("banked_ram: DATA_W (%0d) must exceed BANK_W (%0d)", DATA_W, BANK_W);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                wr_q,    wr_d;
  logic [ADDR_W-1:0]   adr_q,   adr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BANK_W-1:0]   bank_q,  bank_d;
  logic                ready_q, ready_d;
  logic                hit_q,   hit_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode on the captured address
  // ---------------------------------------------------------------------------
  logic [ADDR_W:0]     adr_ext;
  logic                in_fix;
  logic                in_sw;
  logic                in_reg;
  logic [OFF_W-1:0]    off_fix;
  logic [OFF_W-1:0]    off_sw;
  logic [BANK_W-1:0]   eff_bank;
  logic [MEM_AW-1:0]   mem_idx;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_rd;
  logic [DATA_W-1:0]   reg_rd;

  always_comb begin
    adr_ext  = {1'b0, adr_q};
    in_reg   = (adr_q == BANK_REG_ADDR);
    // The bank register wins if it is ever placed inside a RAM window.
    in_fix   = !in_reg && (adr_ext >= FIX_LO) && (adr_ext < FIX_HI);
    in_sw    = !in_reg && (adr_ext >= FIX_HI) && (adr_ext < SW_HI);
    off_fix  = OFF_W'(adr_ext - FIX_LO);
    off_sw   = OFF_W'(adr_ext - FIX_HI);
    // Bank 0 belongs to the fixed window only; selecting it in the switchable
    // window aliases to bank 1.
    eff_bank = (bank_q == '0) ? BANK_W'(1) : bank_q;
    mem_idx  = in_fix ? {BANK_W'(0), off_fix} : {eff_bank, off_sw};
    mem_we   = (state_q == S_DONE) && wr_q && (in_fix || in_sw);
    mem_rd   = mem[mem_idx];
    reg_rd   = {{(DATA_W - BANK_W){1'b1}}, bank_q};
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    bank_d  = bank_q;
    ready_d = 1'b0;
    hit_d   = hit_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = wr;
          adr_d   = adr;
          wdata_d = wdata;
          if (WAIT_STATES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        if (in_reg) begin
          hit_d = 1'b1;
          if (wr_q) begin
            bank_d = wdata_q[BANK_W-1:0];
          end else begin
            rdata_d = reg_rd;
          end
        end else if (in_fix || in_sw) begin
          hit_d = 1'b1;
          if (!wr_q) begin
            rdata_d = mem_rd;
          end
        end else begin
          // Unmapped: writes are dropped, the bus floats high.
          hit_d   = 1'b0;
          rdata_d = OPEN_BUS;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      bank_q  <= BANK_W'(1);
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
      rdata_q <= OPEN_BUS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      bank_q  <= bank_d;
      ready_q <= ready_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the storage array has no reset; clearing it would prevent mapping
  // to block RAM. A reset during an access still drops the write, because the
  // asynchronous reset forces the FSM out of S_DONE before the next edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign hit   = hit_q;
  assign bank  = bank_q;

endmodule
